// File: rtl/gdp_sequencer.sv
// Gaussian distance pipeline sequencer: streams every (senone, component) stat read
// for one observation vector into the gdp pipeline and writes back one score per senone.
module gdp_sequencer #(
    parameter int N_COMPONENTS = 25,
    parameter int N_SENONES    = 500,
    parameter int DATA_W       = 16,
    parameter int RD_LAT       = 1,
    parameter int ADDR_W       = 14,
    parameter int SEN_W        = 9
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [N_COMPONENTS*DATA_W-1:0]   x,
    input  logic                             new_vector,
    output logic                             stat_rd_en,
    output logic [ADDR_W-1:0]                stat_addr,
    input  logic [3*DATA_W-1:0]              stat_data,
    output logic                             gdp_valid,
    output logic                             gdp_first,
    output logic                             gdp_last,
    output logic [DATA_W-1:0]                gdp_x,
    output logic [DATA_W-1:0]                gdp_mean,
    output logic [DATA_W-1:0]                gdp_omega,
    output logic [DATA_W-1:0]                gdp_k,
    input  logic                             gdp_result_valid,
    input  logic [DATA_W-1:0]                gdp_ln_p,
    output logic                             score_we,
    output logic [SEN_W-1:0]                 score_addr,
    output logic [DATA_W-1:0]                score_data,
    output logic                             busy,
    output logic                             gdp_done,
    output logic                             overrun
);

    localparam int CW    = $clog2(N_COMPONENTS);
    localparam int RES_W = SEN_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SENONES * N_COMPONENTS - 1);
    localparam logic [CW-1:0]     LAST_COMP = CW'(N_COMPONENTS - 1);
    localparam logic [RES_W-1:0]  RES_TOTAL = RES_W'(N_SENONES);

    logic [1:0]                              state_q, state_d;
    logic [N_COMPONENTS-1:0][DATA_W-1:0]     x_reg_q, x_reg_d;
    logic [CW-1:0]                           comp_q, comp_d;
    logic [ADDR_W-1:0]                       addr_q, addr_d;
    logic                                    rd_en_q, rd_en_d;
    logic [RES_W-1:0]                        res_cnt_q, res_cnt_d;
    logic                                    busy_q, busy_d;
    logic                                    done_q, done_d;
    logic                                    overrun_q, overrun_d;
    logic                                    score_we_q, score_we_d;
    logic [SEN_W-1:0]                        score_addr_q, score_addr_d;
    logic [DATA_W-1:0]                       score_data_q, score_data_d;
    logic [RD_LAT-1:0]                       tv_q, tv_d, tf_q, tf_d, tl_q, tl_d;
    logic [RD_LAT-1:0][CW-1:0]               tc_q, tc_d;

    // Frame control: issue counters, result collection and overrun tracking.
    always_comb begin
        state_d      = state_q;
        x_reg_d      = x_reg_q;
        comp_d       = comp_q;
        addr_d       = addr_q;
        rd_en_d      = rd_en_q;
        res_cnt_d    = res_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        overrun_d    = overrun_q;
        score_we_d   = 1'b0;
        score_addr_d = score_addr_q;
        score_data_d = score_data_q;
        case (state_q)
            S_IDLE: begin
                if (new_vector) begin
                    state_d   = S_ISSUE;
                    x_reg_d   = x;
                    overrun_d = 1'b0;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    addr_d    = {ADDR_W{1'b0}};
                    comp_d    = {CW{1'b0}};
                    res_cnt_d = {RES_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (addr_q == LAST_ADDR) begin
                    rd_en_d = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    comp_d = (comp_q == LAST_COMP) ? {CW{1'b0}} : comp_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_DRAIN: begin
                if (res_cnt_q == RES_TOTAL) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                rd_en_d = 1'b0;
            end
        endcase

        if (gdp_result_valid && (state_q == S_ISSUE || state_q == S_DRAIN) && (res_cnt_q != RES_TOTAL)) begin
            score_we_d   = 1'b1;
            score_addr_d = res_cnt_q[SEN_W-1:0];
            score_data_d = gdp_ln_p;
            res_cnt_d    = res_cnt_q + {{(RES_W-1){1'b0}}, 1'b1};
        end else begin
            score_we_d = 1'b0;
        end

        // A vector that shows up during DONE is still rejected; only IDLE accepts.
        if (new_vector && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_d;
        end
    end

    // Tag pipe: delays issue-side tags by RD_LAT so they line up with stat_data.
    always_comb begin
        tv_d = tv_q;
        tf_d = tf_q;
        tl_d = tl_q;
        tc_d = tc_q;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            tv_d[i] = tv_q[i-1];
            tf_d[i] = tf_q[i-1];
            tl_d[i] = tl_q[i-1];
            tc_d[i] = tc_q[i-1];
        end
        tv_d[0] = rd_en_q;
        tf_d[0] = rd_en_q && (comp_q == {CW{1'b0}});
        tl_d[0] = rd_en_q && (comp_q == LAST_COMP);
        tc_d[0] = comp_q;
    end

    // Pipeline feed: tags come from flops, stat fields arrive this cycle from storage.
    always_comb begin
        if (tv_q[RD_LAT-1]) begin
            gdp_x     = x_reg_q[tc_q[RD_LAT-1]];
            gdp_mean  = stat_data[3*DATA_W-1 -: DATA_W];
            gdp_omega = stat_data[2*DATA_W-1 -: DATA_W];
            gdp_k     = stat_data[DATA_W-1:0];
        end else begin
            gdp_x     = {DATA_W{1'b0}};
            gdp_mean  = {DATA_W{1'b0}};
            gdp_omega = {DATA_W{1'b0}};
            gdp_k     = {DATA_W{1'b0}};
        end
    end

    assign gdp_valid  = tv_q[RD_LAT-1];
    assign gdp_first  = tf_q[RD_LAT-1];
    assign gdp_last   = tl_q[RD_LAT-1];
    assign stat_rd_en = rd_en_q;
    assign stat_addr  = addr_q;
    assign score_we   = score_we_q;
    assign score_addr = score_addr_q;
    assign score_data = score_data_q;
    assign busy       = busy_q;
    assign gdp_done   = done_q;
    assign overrun    = overrun_q;

    // State registers; an async reset abandons any frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            x_reg_q      <= '0;
            comp_q       <= {CW{1'b0}};
            addr_q       <= {ADDR_W{1'b0}};
            rd_en_q      <= 1'b0;
            res_cnt_q    <= {RES_W{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            score_we_q   <= 1'b0;
            score_addr_q <= {SEN_W{1'b0}};
            score_data_q <= {DATA_W{1'b0}};
            tv_q         <= {RD_LAT{1'b0}};
            tf_q         <= {RD_LAT{1'b0}};
            tl_q         <= {RD_LAT{1'b0}};
            tc_q         <= '0;
        end else begin
            state_q      <= state_d;
            x_reg_q      <= x_reg_d;
            comp_q       <= comp_d;
            addr_q       <= addr_d;
            rd_en_q      <= rd_en_d;
            res_cnt_q    <= res_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            score_we_q   <= score_we_d;
            score_addr_q <= score_addr_d;
            score_data_q <= score_data_d;
            tv_q         <= tv_d;
            tf_q         <= tf_d;
            tl_q         <= tl_d;
            tc_q         <= tc_d;
        end
    end

endmodule

// File: tb/tb_gdp_sequencer.sv
// Directed bench for gdp_sequencer with 3 components, 4 senones and a 2-cycle stat read latency.
module tb_gdp_sequencer;

    localparam int NC = 3;
    localparam int NS = 4;
    localparam int DW = 16;
    localparam int RL = 2;
    localparam int AW = 14;
    localparam int SW = 9;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NC*DW-1:0]  x;
    logic              new_vector;
    logic              stat_rd_en;
    logic [AW-1:0]     stat_addr;
    logic [3*DW-1:0]   stat_data = '0;
    logic              gdp_valid, gdp_first, gdp_last;
    logic [DW-1:0]     gdp_x, gdp_mean, gdp_omega, gdp_k;
    logic              gdp_result_valid;
    logic [DW-1:0]     gdp_ln_p;
    logic              score_we;
    logic [SW-1:0]     score_addr;
    logic [DW-1:0]     score_data;
    logic              busy, gdp_done, overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rd_cnt, gv_cnt, wr_cnt, done_cnt;
    int first_rd_cyc, first_gv_cyc, last_wr_cyc;
    logic [DW-1:0] xe  [NC];
    logic [DW-1:0] lnp [NS];
    logic [AW-1:0] p1 = '0;

    gdp_sequencer #(
        .N_COMPONENTS(NC), .N_SENONES(NS), .DATA_W(DW),
        .RD_LAT(RL), .ADDR_W(AW), .SEN_W(SW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .x(x), .new_vector(new_vector),
        .stat_rd_en(stat_rd_en), .stat_addr(stat_addr), .stat_data(stat_data),
        .gdp_valid(gdp_valid), .gdp_first(gdp_first), .gdp_last(gdp_last),
        .gdp_x(gdp_x), .gdp_mean(gdp_mean), .gdp_omega(gdp_omega), .gdp_k(gdp_k),
        .gdp_result_valid(gdp_result_valid), .gdp_ln_p(gdp_ln_p),
        .score_we(score_we), .score_addr(score_addr), .score_data(score_data),
        .busy(busy), .gdp_done(gdp_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stat memory with two-cycle latency returning {addr, addr+1, addr+2}.
    always @(posedge clk) begin
        p1        <= stat_addr;
        stat_data <= {DW'(p1), DW'(p1 + 14'd1), DW'(p1 + 14'd2)};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic monitor;
        int n;
        forever begin
            @(negedge clk);
            if (stat_rd_en) begin
                if (rd_cnt == 0) first_rd_cyc = cyc;
                chk("stat_addr", 32'(stat_addr), 32'(rd_cnt));
                rd_cnt++;
            end
            if (gdp_valid) begin
                n = gv_cnt;
                if (n == 0) first_gv_cyc = cyc;
                chk("gdp_x", 32'(gdp_x), 32'(xe[n % NC]));
                chk("gdp_first", 32'(gdp_first), 32'((n % NC) == 0));
                chk("gdp_last", 32'(gdp_last), 32'((n % NC) == NC - 1));
                chk("gdp_mean", 32'(gdp_mean), 32'(n));
                chk("gdp_omega", 32'(gdp_omega), 32'(n + 1));
                chk("gdp_k", 32'(gdp_k), 32'(n + 2));
                gv_cnt++;
            end
            if (score_we) begin
                chk("score_in_range", 32'(wr_cnt < NS), 32'd1);
                chk("score_addr", 32'(score_addr), 32'(wr_cnt));
                chk("score_data", 32'(score_data), 32'(lnp[wr_cnt % NS]));
                wr_cnt++;
                last_wr_cyc = cyc;
            end
            if (gdp_done) begin
                done_cnt++;
                chk("done_after_last_write", 32'(cyc), 32'(last_wr_cyc + 1));
                chk("done_write_count", 32'(wr_cnt), 32'(NS));
                chk("done_busy_low", 32'(busy), 32'd0);
            end
        end
    endtask

    task automatic clear_mon;
        rd_cnt = 0; gv_cnt = 0; wr_cnt = 0; done_cnt = 0;
        first_rd_cyc = 0; first_gv_cyc = 0; last_wr_cyc = -10;
    endtask

    task automatic outputs_zero;
        chk("rst_ctrl", 32'({stat_rd_en, gdp_valid, gdp_first, gdp_last, score_we, busy, gdp_done, overrun}), 32'd0);
        chk("rst_stat_addr", 32'(stat_addr), 32'd0);
        chk("rst_gdp_data", 32'(gdp_x | gdp_mean | gdp_omega | gdp_k), 32'd0);
        chk("rst_score", 32'(score_addr) | 32'(score_data), 32'd0);
    endtask

    // Runs one frame; results at offsets 5,8 (issue phase) and 14,17 (drain phase).
    task automatic run_frame(input logic [NC*DW-1:0] xin, input bit ovr, input int base);
        int k;
        for (int c = 0; c < NC; c++) xe[c] = xin[c*DW +: DW];
        for (int j = 0; j < NS; j++) lnp[j] = DW'(base * (j + 1));
        clear_mon();
        x = xin;
        new_vector = 1'b1;
        step();
        x = ~xin;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            new_vector = ovr && (i == 4);
            if (i == 5 || i == 8 || i == 14 || i == 17) begin
                gdp_result_valid = 1'b1;
                gdp_ln_p = lnp[k];
                k++;
            end else begin
                gdp_result_valid = 1'b0;
                gdp_ln_p = '0;
            end
            step();
        end
        new_vector = 1'b0;
        gdp_result_valid = 1'b0;
        for (int w = 0; w < 40 && done_cnt == 0; w++) step();
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("rd_count", 32'(rd_cnt), 32'(NS * NC));
        chk("gdp_count", 32'(gv_cnt), 32'(NS * NC));
        chk("write_count", 32'(wr_cnt), 32'(NS));
        chk("gdp_latency", 32'(first_gv_cyc - first_rd_cyc), 32'(RL));
        chk("overrun_end", 32'(overrun), 32'(ovr));
        chk("busy_end", 32'(busy), 32'd0);
        repeat (2) step();
    endtask

    initial begin
        reset_n = 1'b0;
        new_vector = 1'b0;
        x = '0;
        gdp_result_valid = 1'b0;
        gdp_ln_p = '0;
        clear_mon();
        fork
            monitor();
        join_none
        repeat (3) step();
        outputs_zero();
        reset_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_rd_en", 32'(stat_rd_en), 32'd0);

        run_frame({16'd3, 16'd2, 16'd1}, 1'b0, 10);
        run_frame({16'd60, 16'd50, 16'd40}, 1'b1, 7);

        // Third frame: vector in IDLE clears overrun, then reset lands in DRAIN.
        for (int c = 0; c < NC; c++) xe[c] = DW'(100 + c);
        for (int j = 0; j < NS; j++) lnp[j] = DW'(5 * (j + 1));
        clear_mon();
        x = {16'd102, 16'd101, 16'd100};
        new_vector = 1'b1;
        step();
        new_vector = 1'b0;
        chk("overrun_cleared", 32'(overrun), 32'd0);
        chk("busy_started", 32'(busy), 32'd1);
        for (int i = 1; i < 14; i++) begin
            gdp_result_valid = (i == 5);
            gdp_ln_p = (i == 5) ? lnp[0] : '0;
            step();
        end
        chk("pre_reset_rd_done", 32'(rd_cnt), 32'(NS * NC));
        #2;
        reset_n = 1'b0;
        #1;
        outputs_zero();
        repeat (3) step();
        chk("no_done_after_reset", 32'(done_cnt), 32'd0);
        reset_n = 1'b1;
        step();

        run_frame({16'd9, 16'd8, 16'd7}, 1'b0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
